// File: rtl/tx_resp_arbiter_pkg.sv
// Shared types and constants for the UART TX response arbiter.
package tx_resp_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_RF     = 2'd1,
    SEND_ALU_B0 = 2'd2,
    SEND_ALU_B1 = 2'd3
  } arb_state_e;

  localparam logic GNT_RF  = 1'b0;
  localparam logic GNT_ALU = 1'b1;

  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/tx_resp_arbiter_resp_slot.sv
// One-deep response holding slot: captures a valid pulse, frees on request,
// flags a sticky overrun when a pulse arrives while still occupied.
module resp_slot
  import tx_resp_arbiter_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         free_i,
  input  logic         clr_ovr_i,
  output logic         pend_o,
  output logic [W-1:0] data_o,
  output logic         overrun_o
);

  logic         pend_q, pend_d;
  logic [W-1:0] data_q, data_d;
  logic         ovr_q, ovr_d;
  logic         load;

  always_comb begin
    // A slot being freed this cycle may accept new data without an overrun.
    load   = valid_i & (~pend_q | free_i);
    pend_d = load | (pend_q & ~free_i);
    data_d = load ? data_i : data_q;
    ovr_d  = (valid_i & pend_q & ~free_i) | (ovr_q & ~clr_ovr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      data_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend_o    = pend_q;
  assign data_o    = data_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/tx_resp_arbiter.sv
// Round-robin scheduler of RF and ALU responses onto the TX FIFO write port.
// state       | meaning
// IDLE        | no write this cycle; pick next pending slot
// SEND_RF     | present RF byte, leave when FIFO accepts it
// SEND_ALU_B0 | present first ALU byte
// SEND_ALU_B1 | present second ALU byte, free ALU slot on accept
module tx_resp_arbiter
  import tx_resp_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter bit ALU_LSB_FIRST = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_valid,
  input  logic                    FIFO_FULL,
  input  logic                    CLR_OVERRUN,
  output logic [DATA_WIDTH-1:0]   WR_DATA_FIFO,
  output logic                    WR_INC,
  output logic                    RF_PEND,
  output logic                    ALU_PEND,
  output logic                    RF_OVERRUN,
  output logic                    ALU_OVERRUN
);

  arb_state_e                state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      rf_pend, alu_pend, rf_free, alu_free;
  logic [DATA_WIDTH-1:0]     rf_data;
  logic [2*DATA_WIDTH-1:0]   alu_data;
  logic [DATA_WIDTH-1:0]     alu_first, alu_second;

  assign rf_free  = (state_q == SEND_RF) & ~FIFO_FULL;
  assign alu_free = (state_q == SEND_ALU_B1) & ~FIFO_FULL;

  resp_slot #(.W(DATA_WIDTH)) u_rf_slot (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .valid_i   (RdData_valid),
    .data_i    (RdData),
    .free_i    (rf_free),
    .clr_ovr_i (CLR_OVERRUN),
    .pend_o    (rf_pend),
    .data_o    (rf_data),
    .overrun_o (RF_OVERRUN)
  );

  resp_slot #(.W(2*DATA_WIDTH)) u_alu_slot (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .valid_i   (OUT_valid),
    .data_i    (ALU_OUT),
    .free_i    (alu_free),
    .clr_ovr_i (CLR_OVERRUN),
    .pend_o    (alu_pend),
    .data_o    (alu_data),
    .overrun_o (ALU_OVERRUN)
  );

  assign alu_first  = ALU_LSB_FIRST ? alu_data[DATA_WIDTH-1:0] : alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign alu_second = ALU_LSB_FIRST ? alu_data[2*DATA_WIDTH-1:DATA_WIDTH] : alu_data[DATA_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        // Grant history only matters for ties, so it moves only on a tie.
        if (rf_pend && alu_pend) begin
          if (last_grant_q == GNT_ALU) begin
            state_d      = SEND_RF;
            last_grant_d = GNT_RF;
          end else begin
            state_d      = SEND_ALU_B0;
            last_grant_d = GNT_ALU;
          end
        end else if (rf_pend) begin
          state_d = SEND_RF;
        end else if (alu_pend) begin
          state_d = SEND_ALU_B0;
        end
      end
      SEND_RF:     if (!FIFO_FULL) state_d = IDLE;
      SEND_ALU_B0: if (!FIFO_FULL) state_d = SEND_ALU_B1;
      SEND_ALU_B1: if (!FIFO_FULL) state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    // Output byte follows the state being entered, so it is ready in its first cycle.
    unique case (state_d)
      SEND_RF:     wr_data_d = rf_data;
      SEND_ALU_B0: wr_data_d = alu_first;
      SEND_ALU_B1: wr_data_d = alu_second;
      default:     wr_data_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_ALU;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign WR_DATA_FIFO = wr_data_q;
  assign WR_INC       = (state_q != IDLE) & ~FIFO_FULL;
  assign RF_PEND      = rf_pend;
  assign ALU_PEND     = alu_pend;

endmodule

// File: doc/tx_resp_arbiter.md
Name: tx_resp_arbiter

Overview:
- Schedules the REF_CLK-domain write port of the UART TX async FIFO between two response sources:
  - register-file read data: 8-bit, one byte per response;
  - ALU result: 16-bit, two bytes per response.
- Captures each source's valid pulse into a one-deep holding slot and arbitrates round-robin between the slots.
- Serialises the selected response into byte writes (WR_INC/WR_DATA_FIFO), honouring FIFO_FULL back-pressure.
- Sits between the system controller/ALU/register file and the FIFO write side.

Parameters:
- DATA_WIDTH, 8, FIFO byte width; ALU result width is fixed at 2*DATA_WIDTH.
- ALU_LSB_FIRST, 1, 1 = ALU low byte written first; 0 = high byte first.

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  asynchronous, active-low reset (synchronised reset from the reset synchroniser).
- RdData  in  DATA_WIDTH  register-file read data.
- RdData_valid  in  1  one-cycle pulse qualifying RdData.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- OUT_valid  in  1  one-cycle pulse qualifying ALU_OUT.
- FIFO_FULL  in  1  TX FIFO full flag, write-clock domain.
- CLR_OVERRUN  in  1  synchronous clear of the sticky overrun flags.
- WR_DATA_FIFO  out  DATA_WIDTH  byte presented to the FIFO.
- WR_INC  out  1  FIFO write strobe; a write occurs on each CLK edge where it is high.
- RF_PEND  out  1  RF slot occupied.
- ALU_PEND  out  1  ALU slot occupied.
- RF_OVERRUN  out  1  sticky: RF response dropped.
- ALU_OVERRUN  out  1  sticky: ALU response dropped.

Behaviour:
- Reset (asynchronous, RST=0):
  - All outputs are 0.
  - Both slots are empty; FSM is in IDLE.
  - last_grant = ALU, so RF wins the first tie.
  - A partially sent ALU frame is discarded. No further byte is written for it after reset.
- Capture:
  - RdData_valid=1 with the RF slot empty (or freeing this same cycle) loads RdData at the edge and sets RF_PEND.
  - OUT_valid is handled the same way for the ALU slot.
- Overrun:
  - A valid pulse while the slot is occupied and not freeing that cycle drops the new data, keeps the old data, and sets the source's OVERRUN.
  - OVERRUN holds until CLR_OVERRUN=1, which clears it at the next edge.
  - Simultaneous overrun and CLR_OVERRUN: the set wins.
- FSM states: IDLE, SEND_RF, SEND_ALU_B0, SEND_ALU_B1.
  - IDLE, only RF_PEND -> SEND_RF.
  - IDLE, only ALU_PEND -> SEND_ALU_B0.
  - IDLE, both pending -> the source not equal to last_grant; last_grant is updated on entry.
  - SEND_RF:
    - WR_DATA_FIFO = RF slot.
    - If !FIFO_FULL: byte written, RF slot freed, -> IDLE.
    - Otherwise hold.
  - SEND_ALU_B0:
    - WR_DATA_FIFO = low byte (ALU_LSB_FIRST=1) or high byte.
    - If !FIFO_FULL -> SEND_ALU_B1.
  - SEND_ALU_B1:
    - WR_DATA_FIFO = the other byte.
    - If !FIFO_FULL: ALU slot freed, -> IDLE.
- Write strobe:
  - WR_INC = (state != IDLE) & !FIFO_FULL. This is the only combinational output path.
  - WR_DATA_FIFO is registered from state and slot contents. It is stable for the whole time a state is held under FIFO_FULL.
- Latency:
  - Valid pulse in cycle 0 -> captured at end of cycle 0 -> FSM leaves IDLE at end of cycle 1 -> WR_INC high in cycle 2 (FIFO not full).
  - There is exactly one IDLE bubble cycle between consecutive responses.
- Frame integrity: the two ALU bytes are never interleaved with an RF byte.
- Slot freeing and capture in the same cycle: freeing completes first, the new data is captured, and no overrun is flagged.
- FIFO_FULL rising in SEND_ALU_B1: hold in SEND_ALU_B1. Byte 0 is never re-sent.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, SEND_RF, SEND_ALU_B0, SEND_ALU_B1);
  - grant encoding constants GNT_RF=0, GNT_ALU=1;
  - DATA_WIDTH default.
- One natural sub-module: resp_slot (one-deep holding register with load/free/overrun logic), instantiated twice with widths DATA_WIDTH and 2*DATA_WIDTH.

Test Plan:
- RF only:
  - Stimulus: RdData=8'hA5 pulsed in cycle 0, FIFO_FULL=0.
  - Response: WR_INC=1 with WR_DATA_FIFO=8'hA5 in cycle 2 only; RF_PEND 1 during cycles 1-2, 0 from cycle 3.
- ALU only:
  - Stimulus: ALU_OUT=16'h1234, ALU_LSB_FIRST=1.
  - Response: writes 8'h34 in cycle 2, then 8'h12 in cycle 3; ALU_PEND clears after cycle 3.
- Simultaneous pulses right after reset:
  - Stimulus: RdData=8'h11, ALU_OUT=16'hBEEF in the same cycle.
  - Response: write sequence 8'h11, bubble, 8'hEF, 8'hBE.
  - Repeat the same pulses: sequence becomes 8'hEF, 8'hBE, bubble, 8'h11 (round-robin).
- Back-pressure:
  - Stimulus: FIFO_FULL=1 from cycle 2 for 5 cycles during ALU 16'hCAFE.
  - Response: WR_INC=0 for those 5 cycles with WR_DATA_FIFO held at 8'hFE; then 8'hFE, 8'hCA written once each, no duplicates.
- Overrun:
  - Stimulus: second RdData_valid (8'h77) while 8'h66 is pending under FIFO_FULL=1.
  - Response: RF_OVERRUN=1, only 8'h66 written. CLR_OVERRUN pulse -> RF_OVERRUN=0 next cycle.
- Reset mid-frame:
  - Stimulus: RST asserted between the ALU byte-0 and byte-1 writes.
  - Response: all outputs 0 immediately, byte 1 never written, both PEND=0 after release.
